// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game blocks: bird state encoding and screen geometry.
package flappy_pkg;

  localparam int unsigned PIX_W    = 10;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [1:0] {
    StReady = 2'd0,
    StFly   = 2'd1,
    StFall  = 2'd2,
    StDead  = 2'd3
  } bird_state_e;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button followed by a registered
// one-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q, pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/bird_motion.sv
// Bird vertical motion: flap conditioning, per-frame gravity/flap integration,
// READY/FLY/FALL/DEAD state machine and a registered sprite mask.
module bird_motion
  import flappy_pkg::*;
#(
  parameter int BIRD_X   = 160,
  parameter int BIRD_W   = 16,
  parameter int BIRD_H   = 12,
  parameter int SCREEN_H = 480,
  parameter int START_Y  = 232,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -8,
  parameter int VMAX     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flap,
  input  logic             restart,
  input  logic             hit,
  input  logic             frame_tick,
  input  logic             video_on,
  input  logic [PIX_W-1:0] pixel_x,
  input  logic [PIX_W-1:0] pixel_y,
  output logic             bird_color,
  output logic [PIX_W-1:0] bird_y,
  output logic [1:0]       state,
  output logic             crash
);

  localparam logic [PIX_W-1:0] StartPos = PIX_W'(START_Y);
  localparam logic [PIX_W-1:0] FloorPos = PIX_W'(SCREEN_H - BIRD_H);
  localparam logic signed [10:0] FloorS = 11'(SCREEN_H - BIRD_H);
  localparam logic signed [5:0] GravS   = 6'(GRAVITY);
  localparam logic signed [5:0] FlapS   = 6'(FLAP_VEL);
  localparam logic signed [5:0] VmaxS   = 6'(VMAX);
  localparam logic [10:0] XLo = 11'(BIRD_X);
  localparam logic [10:0] XHi = 11'(BIRD_X + BIRD_W);
  localparam logic [10:0] HgtU = 11'(BIRD_H);

  bird_state_e       state_q, state_d;
  logic [PIX_W-1:0]  y_q, y_d;
  logic signed [5:0] vel_q, vel_d;
  logic              pending_q, pending_d;
  logic              crash_q, crash_d;
  logic              color_q, color_d;

  logic              flap_edge;
  logic              apply_flap;
  logic signed [5:0] vel_inc, vel_new;
  logic signed [10:0] y_new;
  logic              at_floor;
  logic [PIX_W-1:0]  phys_y;
  logic signed [5:0] phys_vel;
  logic              in_x, in_y;

  btn_sync_edge u_flap_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (flap),
    .pulse (flap_edge)
  );

  // An edge landing on the tick itself still counts for that tick.
  assign apply_flap = pending_q | flap_edge;

  always_comb begin
    vel_inc = vel_q + GravS;
    if (apply_flap && (state_q == StFly)) begin
      vel_new = FlapS;
    end else if (vel_inc > VmaxS) begin
      vel_new = VmaxS;
    end else begin
      vel_new = vel_inc;
    end
    y_new    = $signed({1'b0, y_q}) + 11'(vel_new);
    at_floor = !y_new[10] && (y_new >= FloorS);
    if (y_new[10]) begin
      phys_y   = '0;
      phys_vel = '0;
    end else if (at_floor) begin
      phys_y   = FloorPos;
      phys_vel = '0;
    end else begin
      phys_y   = y_new[PIX_W-1:0];
      phys_vel = vel_new;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    unique case (state_q)
      StReady: begin
        y_d   = StartPos;
        vel_d = '0;
        if (flap_edge) state_d = StFly;
      end
      StFly: begin
        if (frame_tick) begin
          y_d   = phys_y;
          vel_d = phys_vel;
        end
        // Floor wins over a coincident hit so only one crash pulse is issued.
        if (frame_tick && at_floor) begin
          state_d = StDead;
        end else if (hit) begin
          state_d = StFall;
        end
      end
      StFall: begin
        if (frame_tick) begin
          y_d   = phys_y;
          vel_d = phys_vel;
          if (at_floor) state_d = StDead;
        end
      end
      StDead: begin
        if (restart) begin
          state_d = StReady;
          y_d     = StartPos;
          vel_d   = '0;
        end
      end
      default: state_d = StReady;
    endcase
  end

  always_comb begin
    crash_d = (state_q == StFly) && (state_d != StFly);
    if ((state_q == StDead) && restart) begin
      pending_d = 1'b0;
    end else if (frame_tick) begin
      // The edge that launches from READY must survive to the first physics tick.
      pending_d = (state_q == StReady) && flap_edge;
    end else begin
      pending_d = pending_q | flap_edge;
    end
  end

  always_comb begin
    in_x    = ({1'b0, pixel_x} >= XLo) && ({1'b0, pixel_x} < XHi);
    in_y    = (pixel_y >= y_q) && ({1'b0, pixel_y} < ({1'b0, y_q} + HgtU));
    color_d = video_on && in_x && in_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StReady;
      y_q       <= StartPos;
      vel_q     <= '0;
      pending_q <= 1'b0;
      crash_q   <= 1'b0;
      color_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      vel_q     <= vel_d;
      pending_q <= pending_d;
      crash_q   <= crash_d;
      color_q   <= color_d;
    end
  end

  assign bird_color = color_q;
  assign bird_y     = y_q;
  assign state      = state_q;
  assign crash      = crash_q;

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion: reset, flap launch, gravity clamp, ceiling,
// hit/fall/floor, restart and sprite rendering.
module tb_bird_motion;

  logic       clk, rst_n, flap, restart, hit, frame_tick, video_on;
  logic [9:0] pixel_x, pixel_y;
  logic       bird_color;
  logic [9:0] bird_y;
  logic [1:0] state;
  logic       crash;

  int n_total = 0;
  int n_pass  = 0;
  int crash_cnt = 0;

  bird_motion dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flap       (flap),
    .restart    (restart),
    .hit        (hit),
    .frame_tick (frame_tick),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .bird_color (bird_color),
    .bird_y     (bird_y),
    .state      (state),
    .crash      (crash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (crash) crash_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic do_flap();
    flap = 1'b1;
    step(5);
    flap = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flap = 0; restart = 0; hit = 0; frame_tick = 0;
    video_on = 0; pixel_x = '0; pixel_y = '0;
    step(2);
    n_total++;
    if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state);
    else n_pass++;
    n_total++;
    if (bird_y !== 10'd232) $display("FAIL reset_y: got %0d expected 232", bird_y);
    else n_pass++;
    n_total++;
    if (bird_color !== 1'b0 || crash !== 1'b0)
      $display("FAIL reset_outs: got color=%0b crash=%0b expected 0/0", bird_color, crash);
    else n_pass++;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_flap_ready();
    do_flap();
    n_total++;
    if (state !== 2'd1 || bird_y !== 10'd232)
      $display("FAIL launch: got state=%0d y=%0d expected 1/232", state, bird_y);
    else n_pass++;
    do_tick();
    n_total++;
    if (bird_y !== 10'd224) $display("FAIL flap_tick1_y: got %0d expected 224", bird_y);
    else n_pass++;
    do_tick();
    n_total++;
    if (bird_y !== 10'd217) $display("FAIL flap_tick2_y: got %0d expected 217", bird_y);
    else n_pass++;
  endtask

  task automatic test_free_fall();
    int exp_y[7] = '{211, 206, 202, 199, 197, 196, 196};
    for (int i = 0; i < 7; i++) begin
      do_tick();
      n_total++;
      if (bird_y !== 10'(exp_y[i]))
        $display("FAIL rise_tick%0d: got %0d expected %0d", i + 3, bird_y, exp_y[i]);
      else n_pass++;
    end
    repeat (10) do_tick();
    n_total++;
    if (bird_y !== 10'd251) $display("FAIL fall_10_ticks: got %0d expected 251", bird_y);
    else n_pass++;
    do_tick();
    n_total++;
    if (bird_y !== 10'd261) $display("FAIL fall_vmax1: got %0d expected 261", bird_y);
    else n_pass++;
    do_tick();
    n_total++;
    if (bird_y !== 10'd271 || state !== 2'd1)
      $display("FAIL fall_vmax2: got y=%0d state=%0d expected 271/1", bird_y, state);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    pixel_x = 10'd160; pixel_y = 10'd271; video_on = 1'b1;
    step(1);
    n_total++;
    if (bird_color !== 1'b1) $display("FAIL pre_reset_color: got %0b expected 1", bird_color);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if (state !== 2'd0 || bird_y !== 10'd232 || bird_color !== 1'b0 || crash !== 1'b0)
      $display("FAIL async_reset: got state=%0d y=%0d color=%0b crash=%0b expected 0/232/0/0",
               state, bird_y, bird_color, crash);
    else n_pass++;
    video_on = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_ceiling();
    do_flap();
    do_tick();
    for (int i = 2; i <= 29; i++) begin
      do_flap();
      do_tick();
    end
    n_total++;
    if (bird_y !== 10'd0 || state !== 2'd1)
      $display("FAIL ceiling_29: got y=%0d state=%0d expected 0/1", bird_y, state);
    else n_pass++;
    do_flap();
    do_tick();
    n_total++;
    if (bird_y !== 10'd0) $display("FAIL ceiling_30: got %0d expected 0", bird_y);
    else n_pass++;
    do_tick();
    n_total++;
    if (bird_y !== 10'd1) $display("FAIL ceiling_vel0: got %0d expected 1", bird_y);
    else n_pass++;
  endtask

  task automatic test_hit_fall();
    repeat (9) do_tick();
    n_total++;
    if (bird_y !== 10'd55) $display("FAIL pre_hit_y: got %0d expected 55", bird_y);
    else n_pass++;
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    n_total++;
    if (state !== 2'd2 || crash !== 1'b1)
      $display("FAIL hit_crash: got state=%0d crash=%0b expected 2/1", state, crash);
    else n_pass++;
    step(1);
    n_total++;
    if (crash !== 1'b0) $display("FAIL crash_width: got %0b expected 0", crash);
    else n_pass++;
    crash_cnt = 0;
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    for (int i = 0; i < 41; i++) begin
      do_flap();
      do_tick();
    end
    n_total++;
    if (bird_y !== 10'd465 || state !== 2'd2)
      $display("FAIL fall_no_flap: got y=%0d state=%0d expected 465/2", bird_y, state);
    else n_pass++;
    do_tick();
    n_total++;
    if (bird_y !== 10'd468 || state !== 2'd3)
      $display("FAIL fall_floor: got y=%0d state=%0d expected 468/3", bird_y, state);
    else n_pass++;
    do_tick();
    step(2);
    n_total++;
    if (bird_y !== 10'd468 || crash_cnt !== 0)
      $display("FAIL dead_frozen: got y=%0d crashes=%0d expected 468/0", bird_y, crash_cnt);
    else n_pass++;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    n_total++;
    if (state !== 2'd0 || bird_y !== 10'd232)
      $display("FAIL restart: got state=%0d y=%0d expected 0/232", state, bird_y);
    else n_pass++;
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    step(2);
    n_total++;
    if (state !== 2'd0 || crash_cnt !== 0)
      $display("FAIL hit_ready: got state=%0d crashes=%0d expected 0/0", state, crash_cnt);
    else n_pass++;
  endtask

  task automatic test_floor_fly();
    do_flap();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    n_total++;
    if (state !== 2'd1) $display("FAIL restart_in_fly: got %0d expected 1", state);
    else n_pass++;
    repeat (40) do_tick();
    n_total++;
    if (bird_y !== 10'd461 || state !== 2'd1 || crash_cnt !== 0)
      $display("FAIL pre_floor: got y=%0d state=%0d crashes=%0d expected 461/1/0",
               bird_y, state, crash_cnt);
    else n_pass++;
    hit = 1'b1;
    do_tick();
    hit = 1'b0;
    step(3);
    n_total++;
    if (bird_y !== 10'd468 || state !== 2'd3 || crash_cnt !== 1)
      $display("FAIL floor_and_hit: got y=%0d state=%0d crashes=%0d expected 468/3/1",
               bird_y, state, crash_cnt);
    else n_pass++;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
  endtask

  task automatic test_render();
    logic [9:0] vx[7] = '{160, 175, 176, 160, 159, 160, 160};
    logic [9:0] vy[7] = '{232, 243, 232, 244, 232, 231, 232};
    logic       vv[7] = '{1, 1, 1, 1, 1, 1, 0};
    logic       ve[7] = '{1, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      pixel_x = vx[i]; pixel_y = vy[i]; video_on = vv[i];
      step(1);
      n_total++;
      if (bird_color !== ve[i])
        $display("FAIL render_%0d_%0d_%0b: got %0b expected %0b",
                 vx[i], vy[i], vv[i], bird_color, ve[i]);
      else n_pass++;
    end
    pixel_x = 10'd160; pixel_y = 10'd232; video_on = 1'b1;
    #1;
    n_total++;
    if (bird_color !== 1'b0) $display("FAIL render_latency: got %0b expected 0", bird_color);
    else n_pass++;
    video_on = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_flap_ready();
    test_free_fall();
    test_reset_midflight();
    test_ceiling();
    test_hit_fall();
    test_floor_fly();
    test_render();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bird_motion.md
# bird_motion

Vertical-motion controller and sprite renderer for the bird. It conditions the flap button and integrates gravity and flap impulses once per video frame. It runs a READY/FLY/FALL/DEAD state machine and drives the per-pixel `bird_color` consumed by the collision/score checker. It sits between the button inputs and VGA pixel counters upstream, and the game-status/score stage downstream.

## Interface
- `BIRD_X`, default 160: fixed left column of the sprite.
- `BIRD_W`, default 16: sprite width in pixels.
- `BIRD_H`, default 12: sprite height in pixels.
- `SCREEN_H`, default 480: visible lines. Floor is `SCREEN_H-BIRD_H` (468).
- `START_Y`, default 232: bird_y in READY.
- `GRAVITY`, default 1: velocity increment per frame.
- `FLAP_VEL`, default -8: signed velocity loaded on flap.
- `VMAX`, default 10: terminal downward velocity.
- `clk` in 1: system clock, the single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `flap` in 1: raw flap button, active-high, asynchronous to `clk`.
- `restart` in 1: synchronous pulse; honoured only in DEAD.
- `hit` in 1: collision flag from the checker; honoured only in FLY.
- `frame_tick` in 1: one-cycle pulse per frame (start of vertical blank).
- `video_on` in 1: current pixel is visible.
- `pixel_x` in 10: current pixel column.
- `pixel_y` in 10: current pixel row.
- `bird_color` out 1: registered; 1 when the current pixel is inside the sprite.
- `bird_y` out 10: sprite top row.
- `state` out 2: READY=0, FLY=1, FALL=2, DEAD=3.
- `crash` out 1: one-cycle pulse when leaving FLY.

## Operation
- **Flap conditioning**
  - `flap` passes through a 2-flop synchronizer, then a rising-edge detect.
  - The edge sets `flap_pending`.
  - `apply_flap = flap_pending | edge_now`, so an edge coincident with `frame_tick` is applied on that tick.
  - `flap_pending` clears on every `frame_tick`. Multiple edges within one frame count as one flap.
- **Physics** (on `frame_tick`, in FLY or FALL only)
  - `vel_new = (apply_flap && state==FLY) ? FLAP_VEL : min(vel+GRAVITY, VMAX)`.
  - `y_new = bird_y + vel_new`.
  - Arithmetic is 11-bit signed for y and 6-bit signed for vel.
  - Ceiling: if `y_new < 0`, then `bird_y=0` and `vel=0`.
  - Floor: if `y_new >= FLOOR`, then `bird_y=FLOOR` and `vel=0`.
- **State machine**
  - READY: `bird_y=START_Y`, `vel=0`. A flap edge goes to FLY; the first physics step happens on the next `frame_tick`, and that step applies the flap.
  - FLY: `hit` goes to FALL and pulses `crash`. Reaching the floor on a tick goes to DEAD and pulses `crash`. If both happen in the same cycle, go to DEAD with a single `crash` pulse.
  - FALL: flaps are ignored; gravity only. Reaching the floor goes to DEAD, with no second `crash`.
  - DEAD: `bird_y` and `vel` are frozen. `restart` goes to READY, reloading `START_Y` and `vel=0`, and clears `flap_pending`.
- `hit` is ignored in READY, FALL and DEAD. `restart` is ignored outside DEAD.
- **Render**: `bird_color <= video_on && BIRD_X<=pixel_x<BIRD_X+BIRD_W && bird_y<=pixel_y<bird_y+BIRD_H`.

## Timing
- Reset (`rst_n`=0, asynchronous) sets: state=READY, `bird_y`=START_Y, `vel`=0, `flap_pending`=0, synchronizer flops=0, `bird_color`=0, `crash`=0.
- Reset asserted mid-flight takes effect immediately, independent of `clk`.
- `flap` to edge detect: 2 cycles of synchronizer plus 1 cycle of edge detect.
- `bird_y` and `vel` update in the cycle after `frame_tick`. `bird_y` therefore changes only during vertical blank, so there is no tearing.
- `bird_color` has 1-cycle latency from `pixel_x`/`pixel_y`/`video_on`. The downstream checker aligns `pipe_color` to match.
- `crash` goes high in the cycle the state register leaves FLY and is low otherwise.

## Structure
- Shared package `flappy_pkg`:
  - state encoding (READY/FLY/FALL/DEAD);
  - `SCREEN_W`=640, `SCREEN_H`=480;
  - pixel-coordinate width (10).
- One sub-module, `btn_sync_edge`: 2-flop synchronizer plus rising-edge pulse with asynchronous active-low reset. It is reused for other buttons.
- Physics, FSM and renderer stay in `bird_motion`.

## Test plan
- **Reset**: `rst_n`=0 mid-FLY with `bird_y`=300 → immediately state=0, `bird_y`=232, `bird_color`=0, `crash`=0.
- **Flap from READY**: flap edge, then 2 `frame_tick`s → state=FLY; `bird_y`=224 (vel −8) after the first tick, 217 (vel −7) after the second.
- **Free fall and clamp**: FLY with vel 0 at y=232, no flaps, 10 ticks → vel=10, y=287. Subsequent ticks add exactly 10 each.
- **Ceiling**: flap on every tick from y=232 → y=0 after 29 ticks. On tick 30, y stays 0 and vel=0.
- **Hit, then fall**:
  - `hit` in FLY at y=100 → one `crash` pulse and state=FALL.
  - Flaps during FALL are ignored; y reaches 468, then state=DEAD.
  - `restart` → READY with y=232.
  - `hit` in READY → no change.
- **Render**: y=232, pixel (160,232) with video_on=1 → `bird_color`=1 one cycle later. Pixels (176,232) and (160,244), or video_on=0 → 0.
